// File: rtl/eq_node_pkg.sv
// ---------------------------------------------------------------------------
// eq_node_pkg
// Shared definitions for the stochastic equality node with edge memory.
//   clog2      : ceiling log2, used to derive the EM address width
//   em_s_legal : edge-memory depth legality (power of two, at least 2)
//   CW_DEFAULT : default width of the hold-event counter
// ---------------------------------------------------------------------------
package eq_node_pkg;

    localparam int CW_DEFAULT = 32'sd8;

    // Ceiling log2 of value; an input of 1 gives 0.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 32'sd0;
        rem = value - 32'sd1;
        while (rem > 32'sd0) begin
            res = res + 32'sd1;
            rem = rem >>> 1;
        end
        return res;
    endfunction

    // A legal depth is a power of two no smaller than 2, so the address
    // width covers the memory exactly and every EM_SEL value is valid.
    function automatic bit em_s_legal(input int depth);
        return (depth >= 32'sd2) && ((depth & (depth - 32'sd1)) == 32'sd0);
    endfunction

endpackage

// File: rtl/eq_node_em_edge_mem.sv
// ---------------------------------------------------------------------------
// edge_mem
// Edge memory: shift register of EM_S bits with a combinational read mux.
//   CLK_D2S : system clock
//   RST     : synchronous active-high reset, clears every bit
//   WE      : shift enable; D enters at bit 0, the oldest bit drops out
//   D       : bit to shift in
//   SEL     : read address
//   OUT     : bit at address SEL (pre-edge contents)
// ---------------------------------------------------------------------------
module edge_mem #(
    parameter int EM_S = 8,
    parameter int AW   = 3
) (
    input  logic          CLK_D2S,
    input  logic          RST,
    input  logic          WE,
    input  logic          D,
    input  logic [AW-1:0] SEL,
    output logic          OUT
);

    logic [EM_S-1:0] r_mem;

    // Shift register storage; bit 0 always holds the most recent write.
    always_ff @(posedge CLK_D2S) begin
        if (RST) begin
            r_mem <= '0;
        end else if (WE) begin
            r_mem <= {r_mem[EM_S-2:0], D};
        end else begin
            r_mem <= r_mem;
        end
    end

    // Reads are only consumed on steps that never write, so no bypass is needed.
    assign OUT = r_mem[SEL];

endmodule

// File: rtl/eq_node_em.sv
// ---------------------------------------------------------------------------
// eq_node_em
// Stochastic equality (variable) node with clocked edge memory.
//   CLK_D2S   : system clock
//   RST       : synchronous active-high reset (overrides EN and INIT)
//   EN        : stochastic bit-step enable
//   INIT      : initialisation phase, EM is loaded from c
//   c         : channel stream bit
//   R         : ND stream bits from the PCNs
//   EM_SEL    : random EM read address
//   Q         : registered output stream bit
//   U_Q       : registered regenerative-update indicator
//   INIT_DONE : EM has been completely filled since the last reset
//   HOLD_CNT  : saturating count of hold steps since reset or INIT
// ---------------------------------------------------------------------------
module eq_node_em
    import eq_node_pkg::*;
#(
    parameter int ND   = 2,
    parameter int EM_S = 8,
    parameter int CW   = CW_DEFAULT
) (
    input  logic                     CLK_D2S,
    input  logic                     RST,
    input  logic                     EN,
    input  logic                     INIT,
    input  logic                     c,
    input  logic [ND-1:0]            R,
    input  logic [clog2(EM_S)-1:0]   EM_SEL,
    output logic                     Q,
    output logic                     U_Q,
    output logic                     INIT_DONE,
    output logic [CW-1:0]            HOLD_CNT
);

    localparam int AW = clog2(EM_S);
    // One extra bit so the fill count can represent EM_S itself.
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] FILL_FULL = FW'(EM_S);

    generate
        if (!em_s_legal(EM_S)) begin : g_bad_em_s
            $error("eq_node_em: EM_S must be a power of two and at least 2");
        end
        if (ND < 1) begin : g_bad_nd
            $error("eq_node_em: ND must be at least 1");
        end
    endgenerate

    logic          w_a1;
    logic          w_a0;
    logic          w_u;
    logic          w_write;
    logic          w_em_out;
    logic          w_q_nxt;
    logic          w_uq_nxt;
    logic [FW-1:0] w_fill_nxt;
    logic [CW-1:0] w_hold_nxt;

    logic          r_q;
    logic          r_uq;
    logic          r_done;
    logic [FW-1:0] r_fill;
    logic [CW-1:0] r_hold;

    // Agreement: every input stream and the channel bit carry the same value.
    assign w_a1    = (&R) & c;
    assign w_a0    = (~|R) & ~c;
    assign w_u     = w_a1 | w_a0;
    assign w_write = EN & (INIT | w_u);

    edge_mem #(
        .EM_S (EM_S),
        .AW   (AW)
    ) u_edge_mem (
        .CLK_D2S (CLK_D2S),
        .RST     (RST),
        .WE      (w_write),
        .D       (c),
        .SEL     (EM_SEL),
        .OUT     (w_em_out)
    );

    // Next-state values for the output, fill and hold-statistics registers.
    always_comb begin
        w_q_nxt    = r_q;
        w_uq_nxt   = r_uq;
        w_fill_nxt = r_fill;
        w_hold_nxt = r_hold;
        if (EN) begin
            if (INIT) begin
                w_q_nxt    = c;
                w_uq_nxt   = 1'b0;
                w_hold_nxt = '0;
                w_fill_nxt = (r_fill == FILL_FULL) ? r_fill : r_fill + FW'(1);
            end else if (w_u) begin
                // On agreement c equals the agreed value of every stream.
                w_q_nxt    = c;
                w_uq_nxt   = 1'b1;
                w_fill_nxt = (r_fill == FILL_FULL) ? r_fill : r_fill + FW'(1);
            end else begin
                w_q_nxt    = w_em_out;
                w_uq_nxt   = 1'b0;
                w_hold_nxt = (r_hold == {CW{1'b1}}) ? r_hold : r_hold + CW'(1);
            end
        end else begin
            w_q_nxt = r_q;
        end
    end

    // State registers; EN=0 leaves every next-state value equal to the current one.
    always_ff @(posedge CLK_D2S) begin
        if (RST) begin
            r_q    <= 1'b0;
            r_uq   <= 1'b0;
            r_done <= 1'b0;
            r_fill <= '0;
            r_hold <= '0;
        end else begin
            r_q    <= w_q_nxt;
            r_uq   <= w_uq_nxt;
            r_fill <= w_fill_nxt;
            r_hold <= w_hold_nxt;
            // Sticky until reset; the fill count cannot drop below full.
            r_done <= r_done | (w_fill_nxt == FILL_FULL);
        end
    end

    assign Q         = r_q;
    assign U_Q       = r_uq;
    assign INIT_DONE = r_done;
    assign HOLD_CNT  = r_hold;

endmodule

// File: tb/tb_eq_node_em.sv
// ---------------------------------------------------------------------------
// tb_eq_node_em
// Self-checking bench for eq_node_em (ND=2, EM_S=8, CW=4). A queue-based
// reference model tracks the edge memory, fill state and hold statistics;
// a compare process checks every cycle, and directed sections add literal
// expectations for the scenarios of interest.
// ---------------------------------------------------------------------------
module tb_eq_node_em;

    localparam int ND   = 2;
    localparam int EM_S = 8;
    localparam int CW   = 4;
    localparam int HMAX = (1 << CW) - 1;

    logic            clk;
    logic            RST;
    logic            EN;
    logic            INIT;
    logic            c;
    logic [ND-1:0]   R;
    logic [2:0]      EM_SEL;
    logic            Q;
    logic            U_Q;
    logic            INIT_DONE;
    logic [CW-1:0]   HOLD_CNT;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model state; em_q[0] is the most recently written bit.
    bit em_q[$];
    int m_fill;
    bit m_done;
    int m_hold;
    bit m_q;
    bit m_uq;

    eq_node_em #(
        .ND   (ND),
        .EM_S (EM_S),
        .CW   (CW)
    ) dut (
        .CLK_D2S   (clk),
        .RST       (RST),
        .EN        (EN),
        .INIT      (INIT),
        .c         (c),
        .R         (R),
        .EM_SEL    (EM_SEL),
        .Q         (Q),
        .U_Q       (U_Q),
        .INIT_DONE (INIT_DONE),
        .HOLD_CNT  (HOLD_CNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, advanced on every rising edge from the applied inputs.
    always @(posedge clk) begin : model
        bit agree;
        if (RST) begin
            em_q = {};
            for (int i = 0; i < EM_S; i++) em_q.push_back(1'b0);
            m_fill = 0;
            m_done = 1'b0;
            m_hold = 0;
            m_q    = 1'b0;
            m_uq   = 1'b0;
        end else if (EN) begin
            agree = ((R == {ND{1'b1}}) && c) || ((R == '0) && !c);
            if (INIT || agree) begin
                em_q.push_front(c);
                void'(em_q.pop_back());
                m_q  = c;
                m_uq = !INIT;
                if (m_fill < EM_S) m_fill++;
                if (m_fill == EM_S) m_done = 1'b1;
                if (INIT) m_hold = 0;
            end else begin
                m_q  = em_q[EM_SEL];
                m_uq = 1'b0;
                if (m_hold < HMAX) m_hold++;
            end
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_Q", {31'd0, Q}, {31'd0, m_q});
            check("model_U_Q", {31'd0, U_Q}, {31'd0, m_uq});
            check("model_INIT_DONE", {31'd0, INIT_DONE}, {31'd0, m_done});
            check("model_HOLD_CNT", {28'd0, HOLD_CNT}, m_hold);
        end
    end

    // Drive one step's inputs at a falling edge and wait past the next rising edge.
    task automatic apply(input bit rst, input bit en, input bit init, input bit cc,
                         input bit [ND-1:0] r, input bit [2:0] sel);
        RST    = rst;
        EN     = en;
        INIT   = init;
        c      = cc;
        R      = r;
        EM_SEL = sel;
        @(negedge clk);
    endtask

    function automatic bit rb();
        return bit'($urandom_range(1, 0));
    endfunction

    function automatic bit [ND-1:0] rr();
        return ND'($urandom_range((1 << ND) - 1, 0));
    endfunction

    function automatic bit [2:0] rs();
        return 3'($urandom_range(EM_S - 1, 0));
    endfunction

    bit cseq[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bit exp_rd[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        RST = 1'b1; EN = 1'b0; INIT = 1'b0; c = 1'b0; R = '0; EM_SEL = '0;

        // Reset with random other inputs.
        apply(1'b1, rb(), rb(), rb(), rr(), rs());
        chk_en = 1'b1;
        apply(1'b1, rb(), rb(), rb(), rr(), rs());
        check("rst_Q", {31'd0, Q}, 32'd0);
        check("rst_U_Q", {31'd0, U_Q}, 32'd0);
        check("rst_INIT_DONE", {31'd0, INIT_DONE}, 32'd0);
        check("rst_HOLD_CNT", {28'd0, HOLD_CNT}, 32'd0);
        for (int k = 0; k < EM_S; k++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 3'(k));
            check("rst_em_read", {31'd0, Q}, 32'd0);
        end

        // Init fill with a fixed pattern.
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b1, 1'b1, cseq[i], rr(), rs());
            if (i == 0) check("init_clears_hold", {28'd0, HOLD_CNT}, 32'd0);
            if (i == 6) check("init_done_step7", {31'd0, INIT_DONE}, 32'd0);
            if (i == 7) check("init_done_step8", {31'd0, INIT_DONE}, 32'd1);
        end
        for (int k = 0; k < EM_S; k++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 3'(k));
            check("fill_read_Q", {31'd0, Q}, {31'd0, exp_rd[k]});
        end

        // Regenerative steps in both polarities.
        apply(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, rs());
        check("regen1_Q", {31'd0, Q}, 32'd1);
        check("regen1_U_Q", {31'd0, U_Q}, 32'd1);
        apply(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 3'd0);
        check("regen1_em0", {31'd0, Q}, 32'd1);
        check("hold_U_Q", {31'd0, U_Q}, 32'd0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, rs());
        check("regen0_Q", {31'd0, Q}, 32'd0);
        check("regen0_U_Q", {31'd0, U_Q}, 32'd1);
        check("pre_gate_hold", {28'd0, HOLD_CNT}, 32'd9);

        // EN gating: nothing moves while EN is low.
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, rb(), rb(), rr(), rs());
            check("gate_Q", {31'd0, Q}, 32'd0);
            check("gate_U_Q", {31'd0, U_Q}, 32'd1);
            check("gate_hold", {28'd0, HOLD_CNT}, 32'd9);
        end
        for (int k = 0; k < EM_S; k++) apply(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 3'(k));

        // Hold counter saturation, then an INIT step clears it.
        apply(1'b0, 1'b1, 1'b1, rb(), rr(), rs());
        check("sat_pre_clear", {28'd0, HOLD_CNT}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, rs());
            if (i == 14) check("sat_reach", {28'd0, HOLD_CNT}, 32'd15);
        end
        check("sat_stay", {28'd0, HOLD_CNT}, 32'd15);
        apply(1'b0, 1'b1, 1'b1, rb(), rr(), rs());
        check("sat_init_clear", {28'd0, HOLD_CNT}, 32'd0);

        // Reset in the middle of an init sequence.
        apply(1'b1, rb(), rb(), rb(), rr(), rs());
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 1'b1, rb(), rr(), rs());
        apply(1'b1, 1'b1, 1'b1, rb(), rr(), rs());
        check("midrst_done", {31'd0, INIT_DONE}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b1, 1'b1, rb(), rr(), rs());
            if (i == 6) check("midrst_step7", {31'd0, INIT_DONE}, 32'd0);
            if (i == 7) check("midrst_step8", {31'd0, INIT_DONE}, 32'd1);
        end

        // Randomized traffic checked by the model.
        for (int i = 0; i < 600; i++) begin
            apply(($urandom_range(99, 0) < 2), ($urandom_range(99, 0) < 75),
                  ($urandom_range(99, 0) < 10), rb(), rr(), rs());
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
